// File: rtl/avr_fetch_queue.sv
// avr_fetch_queue: prefetching instruction queue between synchronous program
// memory and the AVR decoder. It tags every word with its word address, and it
// presents 32-bit instructions (LDS/STS/JMP/CALL) as one unit with their
// second word. An absolute redirect flushes the queue and restarts fetch.
module avr_fetch_queue #(
    parameter int              PC_W       = 16,
    parameter int              QDEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter bit              SWAP_BYTES = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST,
    output logic [PC_W-1:0]             prog_addr,
    output logic                        prog_en,
    input  logic [15:0]                 prog_data,
    input  logic                        redirect_valid,
    input  logic [PC_W-1:0]             redirect_target,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [15:0]                 instr,
    output logic [15:0]                 instr_ext,
    output logic                        instr_is32,
    output logic [PC_W-1:0]             instr_pc,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LVL_W = CNT_W + 1;

    // Two-word AVR opcodes: LDS/STS (1001 00xd dddd 0000) and JMP/CALL (1001 010k kkkk 11xk).
    function automatic logic is_32bit(input logic [15:0] w);
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction

    // Optional byte swap for little-endian flash images.
    function automatic logic [15:0] order_word(input logic [15:0] w);
        if (SWAP_BYTES) begin
            return {w[7:0], w[15:8]};
        end else begin
            return w;
        end
    endfunction

    logic [15:0]     q_word [QDEPTH];
    logic [PC_W-1:0] q_pc   [QDEPTH];

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PC_W-1:0]  fetch_pc_r;
    logic [PC_W-1:0]  inflight_pc_r;
    logic             inflight_r;
    logic             discard_r;

    logic [PTR_W-1:0] next_rd_s;
    logic [15:0]      head_word_s;
    logic [15:0]      ext_word_s;
    logic             head_is32_s;
    logic [LVL_W-1:0] level_s;
    logic             valid_s;
    logic             fetch_en_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] pop_n_s;

    // Head decode, occupancy accounting and handshake qualification.
    always_comb begin
        next_rd_s   = rd_ptr_r + PTR_W'(1);
        head_word_s = q_word[rd_ptr_r];
        ext_word_s  = q_word[next_rd_s];
        head_is32_s = is_32bit(head_word_s);
        // In-flight reads reserve a slot so the queue can never overflow.
        level_s     = LVL_W'(count_r) + LVL_W'(inflight_r);
        fetch_en_s  = !RST && !redirect_valid && (level_s < LVL_W'(QDEPTH));
        valid_s     = !RST && (((count_r >= CNT_W'(1)) && !head_is32_s) ||
                               ((count_r >= CNT_W'(2)) &&  head_is32_s));
        push_s      = inflight_r && !discard_r && !redirect_valid;
        pop_s       = valid_s && instr_ready && !redirect_valid;
        if (head_is32_s) begin
            pop_n_s = CNT_W'(2);
        end else begin
            pop_n_s = CNT_W'(1);
        end
    end

    // Presented instruction: zeroed whenever the head is not a complete instruction.
    always_comb begin
        prog_addr   = fetch_pc_r;
        prog_en     = fetch_en_s;
        instr_valid = valid_s;
        q_count     = count_r;
        instr       = 16'h0000;
        instr_ext   = 16'h0000;
        instr_is32  = 1'b0;
        instr_pc    = '0;
        if (valid_s) begin
            instr      = head_word_s;
            instr_pc   = q_pc[rd_ptr_r];
            instr_is32 = head_is32_s;
            if (head_is32_s) begin
                instr_ext = ext_word_s;
            end else begin
                instr_ext = 16'h0000;
            end
        end else begin
            instr = 16'h0000;
        end
    end

    // Queue storage: the returning read lands at the write pointer with its address.
    always_ff @(posedge CLK) begin
        if (push_s && !RST) begin
            q_word[wr_ptr_r] <= order_word(prog_data);
            q_pc[wr_ptr_r]   <= inflight_pc_r;
        end
    end

    // Control state: fetch PC, pointers, occupancy, in-flight and discard tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            fetch_pc_r    <= RESET_PC;
            inflight_pc_r <= '0;
            inflight_r    <= 1'b0;
            discard_r     <= 1'b0;
        end else if (redirect_valid) begin
            // Flush; a simultaneous pop is ignored and any read in flight is dropped.
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            fetch_pc_r <= redirect_target;
            inflight_r <= 1'b0;
            discard_r  <= inflight_r;
        end else begin
            discard_r  <= 1'b0;
            inflight_r <= fetch_en_s;
            if (fetch_en_s) begin
                fetch_pc_r    <= fetch_pc_r + PC_W'(1);
                inflight_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(pop_n_s);
                count_r  <= count_r + CNT_W'(push_s) - pop_n_s;
            end else begin
                count_r  <= count_r + CNT_W'(push_s);
            end
        end
    end

endmodule

// File: tb/tb_avr_fetch_queue.sv
// Directed, table-driven bench for avr_fetch_queue. A second instance with
// byte swapping and a reset PC near the top of the address space covers the
// swap path and fetch address wrap.
module tb_avr_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic        instr_ready = 1'b0;

    logic [15:0] prog_addr, instr, instr_ext, instr_pc, prog_data;
    logic        prog_en, instr_valid, instr_is32;
    logic [2:0]  q_count;

    logic [15:0] prog_addr2, instr2, instr_ext2, instr_pc2, prog_data2;
    logic        prog_en2, instr_valid2, instr_is32_2;
    logic [2:0]  q_count2;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    avr_fetch_queue #(.PC_W(16), .QDEPTH(4), .RESET_PC(16'h0000), .SWAP_BYTES(1'b0)) dut (
        .CLK(CLK), .RST(RST), .prog_addr(prog_addr), .prog_en(prog_en), .prog_data(prog_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_ext(instr_ext), .instr_is32(instr_is32), .instr_pc(instr_pc), .q_count(q_count)
    );

    avr_fetch_queue #(.PC_W(16), .QDEPTH(4), .RESET_PC(16'hFFFE), .SWAP_BYTES(1'b1)) dut_sw (
        .CLK(CLK), .RST(RST), .prog_addr(prog_addr2), .prog_en(prog_en2), .prog_data(prog_data2),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid2), .instr_ready(instr_ready), .instr(instr2),
        .instr_ext(instr_ext2), .instr_is32(instr_is32_2), .instr_pc(instr_pc2), .q_count(q_count2)
    );

    // Program image for the straight instance: word i = i, with a JMP at 5 and a CALL at 0x100.
    function automatic logic [15:0] mem1(input logic [15:0] a);
        case (a)
            16'h0005: return 16'h940C;
            16'h0006: return 16'h1234;
            16'h0100: return 16'h940E;
            16'h0101: return 16'hABCD;
            default:  return a;
        endcase
    endfunction

    // Program image for the swapping instance (raw little-endian bytes).
    function automatic logic [15:0] mem2(input logic [15:0] a);
        case (a)
            16'hFFFE: return 16'h3412;
            16'hFFFF: return 16'h0000;
            16'h0000: return 16'h0C94;
            16'h0001: return 16'h7856;
            default:  return 16'h0000;
        endcase
    endfunction

    initial prog_data  = 16'h0000;
    initial prog_data2 = 16'h0000;

    // Synchronous program memories with one-cycle read latency.
    always @(posedge CLK) begin
        if (prog_en)  prog_data  <= mem1(prog_addr);
        if (prog_en2) prog_data2 <= mem2(prog_addr2);
    end

    typedef struct {
        logic        rst;
        logic        rv;
        logic [15:0] rt;
        logic        rdy;
        logic        chk;
        logic        en;
        logic [15:0] addr;
        logic        v;
        logic [15:0] ins;
        logic [15:0] ext;
        logic        is32;
        logic [15:0] pc;
        logic [2:0]  q;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic rv, input logic [15:0] rt, input logic rdy,
                       input logic chk, input logic en, input logic [15:0] addr, input logic v,
                       input logic [15:0] ins, input logic [15:0] ext, input logic is32,
                       input logic [15:0] pc, input logic [2:0] q);
        vec_t r;
        r.rst = rst; r.rv = rv; r.rt = rt; r.rdy = rdy; r.chk = chk; r.en = en; r.addr = addr;
        r.v = v; r.ins = ins; r.ext = ext; r.is32 = is32; r.pc = pc; r.q = q;
        vq.push_back(r);
    endtask

    task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
        end
    endtask

    initial begin
        //   rst rv  target    rdy chk en  addr     v  instr     ext       32 pc        q
        add(1, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 0 reset
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 1
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 2
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0002, 1, 16'h0000, 16'h0000, 0, 16'h0000, 3'd1); // 3 first valid
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0003, 1, 16'h0001, 16'h0000, 0, 16'h0001, 3'd1); // 4
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0004, 1, 16'h0002, 16'h0000, 0, 16'h0002, 3'd1); // 5
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0005, 1, 16'h0003, 16'h0000, 0, 16'h0003, 3'd1); // 6
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0006, 1, 16'h0004, 16'h0000, 0, 16'h0004, 3'd1); // 7
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0007, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd1); // 8 partial JMP
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0008, 1, 16'h940C, 16'h1234, 1, 16'h0005, 3'd2); // 9 JMP pops 2
        add(0, 0, 16'h0000, 0, 1, 1, 16'h0009, 1, 16'h0007, 16'h0000, 0, 16'h0007, 3'd1); // 10 stall
        add(0, 0, 16'h0000, 0, 1, 1, 16'h000A, 1, 16'h0007, 16'h0000, 0, 16'h0007, 3'd2); // 11
        add(0, 0, 16'h0000, 0, 1, 0, 16'h000B, 1, 16'h0007, 16'h0000, 0, 16'h0007, 3'd3); // 12 reserved slot
        add(0, 0, 16'h0000, 0, 1, 0, 16'h000B, 1, 16'h0007, 16'h0000, 0, 16'h0007, 3'd4); // 13 full
        add(0, 0, 16'h0000, 0, 1, 0, 16'h000B, 1, 16'h0007, 16'h0000, 0, 16'h0007, 3'd4); // 14
        add(0, 0, 16'h0000, 1, 1, 0, 16'h000B, 1, 16'h0007, 16'h0000, 0, 16'h0007, 3'd4); // 15 release
        add(0, 0, 16'h0000, 1, 1, 1, 16'h000B, 1, 16'h0008, 16'h0000, 0, 16'h0008, 3'd3); // 16 resume
        add(0, 0, 16'h0000, 1, 1, 1, 16'h000C, 1, 16'h0009, 16'h0000, 0, 16'h0009, 3'd2); // 17
        add(0, 0, 16'h0000, 0, 1, 1, 16'h000D, 1, 16'h000A, 16'h0000, 0, 16'h000A, 3'd2); // 18
        add(0, 1, 16'h0100, 0, 1, 0, 16'h000E, 1, 16'h000A, 16'h0000, 0, 16'h000A, 3'd3); // 19 redirect, read in flight
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 20 flushed
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0101, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 21
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0102, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd1); // 22 CALL partial
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0103, 1, 16'h940E, 16'hABCD, 1, 16'h0100, 3'd2); // 23 CALL
        add(0, 1, 16'h0200, 1, 1, 0, 16'h0104, 1, 16'h0102, 16'h0000, 0, 16'h0102, 3'd1); // 24 redirect + ready
        add(0, 1, 16'h0300, 1, 1, 0, 16'h0200, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 25 back-to-back
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0300, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 26
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0301, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 27
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0302, 1, 16'h0300, 16'h0000, 0, 16'h0300, 3'd1); // 28
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0303, 1, 16'h0301, 16'h0000, 0, 16'h0301, 3'd1); // 29
        add(1, 1, 16'h0500, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 30 reset beats redirect
        add(0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0); // 31

        repeat (2) @(posedge CLK);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            RST             = vq[i].rst;
            redirect_valid  = vq[i].rv;
            redirect_target = vq[i].rt;
            instr_ready     = vq[i].rdy;
            #1;
            if (vq[i].chk) begin
                check("prog_en",     i, 32'(prog_en),     32'(vq[i].en));
                check("prog_addr",   i, 32'(prog_addr),   32'(vq[i].addr));
                check("instr_valid", i, 32'(instr_valid), 32'(vq[i].v));
                check("instr",       i, 32'(instr),       32'(vq[i].ins));
                check("instr_ext",   i, 32'(instr_ext),   32'(vq[i].ext));
                check("instr_is32",  i, 32'(instr_is32),  32'(vq[i].is32));
                check("instr_pc",    i, 32'(instr_pc),    32'(vq[i].pc));
                check("q_count",     i, 32'(q_count),     32'(vq[i].q));
            end
            if (i == 31) begin
                check("sw_prog_addr", i, 32'(prog_addr2), 32'h0000_FFFE);
                check("sw_prog_en",   i, 32'(prog_en2),   32'h1);
            end
        end

        // Swapping instance: byte order, 32-bit detection after swap, PC wrap.
        @(negedge CLK); #1;
        check("sw_wrap_addr", 32, 32'(prog_addr2),   32'h0000_FFFF);
        check("sw_valid",     32, 32'(instr_valid2), 32'h0);
        @(negedge CLK); #1;
        check("sw_wrap_addr", 33, 32'(prog_addr2),   32'h0000_0000);
        check("sw_instr",     33, 32'(instr2),       32'h0000_1234);
        check("sw_pc",        33, 32'(instr_pc2),    32'h0000_FFFE);
        @(negedge CLK); #1;
        check("sw_instr",     34, 32'(instr2),       32'h0000_0000);
        check("sw_pc",        34, 32'(instr_pc2),    32'h0000_FFFF);
        check("sw_valid",     34, 32'(instr_valid2), 32'h1);
        @(negedge CLK); #1;
        check("sw_partial",   35, 32'(instr_valid2), 32'h0);
        check("sw_q_count",   35, 32'(q_count2),     32'h1);
        @(negedge CLK); #1;
        check("sw_valid",     36, 32'(instr_valid2), 32'h1);
        check("sw_instr",     36, 32'(instr2),       32'h0000_940C);
        check("sw_ext",       36, 32'(instr_ext2),   32'h0000_5678);
        check("sw_is32",      36, 32'(instr_is32_2), 32'h1);
        check("sw_pc",        36, 32'(instr_pc2),    32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
